// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding and frame geometry for the PS/2 receiver
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  localparam int DATA_BITS = 8;
  localparam int HIST_BYTES = 3;
endpackage

// File: rtl/ps2_sync_filter.sv
// ps2_sync_filter: 2-FF synchroniser plus FILTER_LEN-sample glitch filter, idles high
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_filt
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  // flip the filtered value only after FILTER_LEN consecutive disagreeing samples
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync <= 2'b11;
      cnt <= '0;
      o_filt <= 1'b1;
    end else begin
      sync <= {sync[0], i_pin};
      if (sync[1] == o_filt) cnt <= '0;
      else if (cnt == CW'(FILTER_LEN - 1)) begin
        cnt <= '0;
        o_filt <= sync[1];
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 frame receiver with 3-byte scancode history; PS2_RX_PARITY_CHECK_EN enables odd-parity rejection
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic [8*HIST_BYTES-1:0] o_ps2_data,
  output logic o_valid,
  output logic o_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(DATA_BITS);
  state_t state, nxt;
  logic filt_clk, filt_data, filt_clk_q, fall, tmo, ok;
  logic [BW-1:0] bcnt;
  logic [DATA_BITS-1:0] sr;
  logic [TW-1:0] tcnt;
  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk (.i_clk(i_clk), .i_rst(i_rst), .i_pin(i_ps2_clk), .o_filt(filt_clk));
  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_data (.i_clk(i_clk), .i_rst(i_rst), .i_pin(i_ps2_data), .o_filt(filt_data));
  assign fall = filt_clk_q & ~filt_clk;
`ifdef PS2_RX_PARITY_CHECK_EN
  logic par;
  assign ok = filt_data & (^{sr, par});
`else
  assign ok = filt_data;
`endif
  // state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else state <= nxt;
  end
  // next state: advance on filtered clock fall, abort to IDLE on timeout (a fall always wins)
  always_comb begin
    tmo = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    case (state)
      IDLE:    nxt = (fall && !filt_data) ? DATA : IDLE;
      DATA:    nxt = (fall && bcnt == BW'(DATA_BITS - 1)) ? PARITY : DATA;
      PARITY:  nxt = fall ? STOP : PARITY;
      STOP:    nxt = fall ? IDLE : STOP;
      default: nxt = IDLE;
    endcase
    if (tmo) nxt = IDLE;
  end
  // edge history, counters, shift register, history and one-cycle result pulses
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      filt_clk_q <= 1'b1;
      bcnt <= '0;
      sr <= '0;
      tcnt <= '0;
      o_ps2_data <= '0;
      o_valid <= 1'b0;
      o_err <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
      par <= 1'b0;
`endif
    end else begin
      filt_clk_q <= filt_clk;
      o_valid <= 1'b0;
      o_err <= tmo;
      tcnt <= (state == IDLE || fall || tmo) ? '0 : tcnt + 1'b1;
      if (fall) begin
        if (state == IDLE) bcnt <= '0;
        if (state == DATA) begin
          sr <= {filt_data, sr[DATA_BITS-1:1]};
          bcnt <= bcnt + 1'b1;
        end
`ifdef PS2_RX_PARITY_CHECK_EN
        if (state == PARITY) par <= filt_data;
`endif
        if (state == STOP) begin
          o_valid <= ok;
          o_err <= ~ok;
          if (ok) o_ps2_data <= {o_ps2_data[8*HIST_BYTES-9:0], sr};
        end
      end
    end
  end
endmodule
